// File: rtl/i2c_target_regif_if.sv
// i2c_target_regif_if: pad and register-bus signals of the I2C target.
// scl/sda: synchronised-inside pad inputs; sda_oe: open-drain pull-low request;
// reg_*: single-cycle register bus; busy: transaction in progress.
interface i2c_target_regif_if;
    logic       scl;
    logic       sda;
    logic       sda_oe;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_wr;
    logic       reg_rd;
    logic [7:0] reg_rdata;
    logic       busy;
    modport slave (
        input  scl, sda, reg_rdata,
        output sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
    modport master (
        output scl, sda, reg_rdata,
        input  sda_oe, reg_addr, reg_wdata, reg_wr, reg_rd, busy
    );
endinterface

// File: rtl/i2c_target_regif.sv
// i2c_target_regif: I2C target with offset byte and auto-incrementing register reads/writes.
// Ports: sysclk (rising edge), reset_n (synchronous, active low), bus (slave modport:
// scl/sda pad inputs, sda_oe open-drain drive, reg_addr/reg_wdata/reg_wr/reg_rd/reg_rdata, busy).
module i2c_target_regif #(
    parameter logic [6:0] DEV_ADDR = 7'h40,
    parameter int         FILT_LEN = 3
) (
    input  logic              sysclk,
    input  logic              reset_n,
    i2c_target_regif_if.slave bus
);
    localparam logic [3:0] IDLE  = 4'd0;
    localparam logic [3:0] DEVA  = 4'd1;
    localparam logic [3:0] DACK  = 4'd2;
    localparam logic [3:0] OFS   = 4'd3;
    localparam logic [3:0] OACK  = 4'd4;
    localparam logic [3:0] WDATA = 4'd5;
    localparam logic [3:0] WACK  = 4'd6;
    localparam logic [3:0] RDATA = 4'd7;
    localparam logic [3:0] MACK  = 4'd8;
    localparam logic [3:0] WAITP = 4'd9;

    // bit 1 = scl, bit 0 = sda; all preset to the idle-high bus level
    logic [1:0] s1, s2, f, d;
    logic [2:0] fc [2];
    logic [3:0] state;
    logic [2:0] cnt;
    logic [7:0] sh;
    logic [7:0] nb;
    logic       rw, ph, rd_d;
    logic       sda_oe, reg_wr, reg_rd, busy;
    logic [7:0] reg_addr, reg_wdata;
    logic       scl_rise, scl_fall, start, stop;

    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            s1 <= '1;
            s2 <= '1;
            f <= '1;
            d <= '1;
            fc[0] <= '0;
            fc[1] <= '0;
        end else begin
            s1 <= {bus.scl, bus.sda};
            s2 <= s1;
            d <= f;
            for (int i = 0; i < 2; i++) begin
                if (s2[i] == f[i]) begin
                    fc[i] <= '0;
                end else if (fc[i] == 3'(FILT_LEN - 1)) begin
                    f[i] <= s2[i];
                    fc[i] <= '0;
                end else begin
                    fc[i] <= fc[i] + 3'd1;
                end
            end
        end
    end

    assign scl_rise = f[1] & ~d[1];
    assign scl_fall = ~f[1] & d[1];
    assign start = f[1] & d[0] & ~f[0];
    assign stop = f[1] & ~d[0] & f[0];
    assign nb = {sh[6:0], f[0]};

    // ph marks the second half of an ack slot: 0 until the SCL fall after bit 8,
    // then 1 until the SCL fall after bit 9 ends the slot.
    always_ff @(posedge sysclk) begin
        if (!reset_n) begin
            state <= IDLE;
            cnt <= '0;
            sh <= '0;
            rw <= 1'b0;
            ph <= 1'b0;
            rd_d <= 1'b0;
            sda_oe <= 1'b0;
            reg_addr <= '0;
            reg_wdata <= '0;
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            busy <= 1'b0;
        end else begin
            reg_wr <= 1'b0;
            reg_rd <= 1'b0;
            rd_d <= reg_rd;
            if (reg_wr) reg_addr <= reg_addr + 8'd1;
            // read data arrives one cycle after the strobe
            if (rd_d) begin
                sh <= bus.reg_rdata;
                reg_addr <= reg_addr + 8'd1;
            end
            if (start) begin
                state <= DEVA;
                cnt <= '0;
                sda_oe <= 1'b0;
                busy <= 1'b1;
            end else if (stop) begin
                state <= IDLE;
                sda_oe <= 1'b0;
                busy <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    DEVA, OFS, WDATA: begin
                        sh <= nb;
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            ph <= 1'b0;
                            if (state == DEVA) begin
                                rw <= f[0];
                                state <= (nb[7:1] == DEV_ADDR) ? DACK : WAITP;
                            end else if (state == OFS) begin
                                reg_addr <= nb;
                                state <= OACK;
                            end else begin
                                reg_wdata <= nb;
                                reg_wr <= 1'b1;
                                state <= WACK;
                            end
                        end
                    end
                    RDATA: begin
                        sh <= {sh[6:0], 1'b1};
                        cnt <= cnt + 3'd1;
                        if (cnt == 3'd7) begin
                            ph <= 1'b0;
                            state <= MACK;
                        end
                    end
                    DACK: if (ph && rw) reg_rd <= 1'b1;
                    MACK: begin
                        if (ph && f[0]) state <= WAITP;
                        if (ph && !f[0]) reg_rd <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    RDATA: sda_oe <= ~sh[7];
                    DACK, OACK, WACK, MACK: begin
                        if (!ph) begin
                            ph <= 1'b1;
                            sda_oe <= (state != MACK);
                        end else begin
                            cnt <= '0;
                            sda_oe <= ((state == DACK && rw) || state == MACK) ? ~sh[7] : 1'b0;
                            state <= (state == DACK) ? (rw ? RDATA : OFS) :
                                     (state == MACK) ? RDATA : WDATA;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.sda_oe = sda_oe;
    assign bus.reg_addr = reg_addr;
    assign bus.reg_wdata = reg_wdata;
    assign bus.reg_wr = reg_wr;
    assign bus.reg_rd = reg_rd;
    assign bus.busy = busy;
endmodule

// File: tb/tb_i2c_target_regif.sv
// tb_i2c_target_regif: bit-banged I2C master plus register-file and transaction reference model.
module tb_i2c_target_regif;
    localparam int Q = 8;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;
    logic [7:0] rdata = 8'h00;
    logic line;
    int errors = 0;
    int checks = 0;
    int excl_cnt = 0;
    int oe_cnt = 0;
    int ptr = 0;
    logic [7:0] rf [256];
    logic [7:0] ref_mem [256];
    logic [7:0] dbuf [8];
    logic [15:0] wq [$];
    logic [7:0] rq [$];

    i2c_target_regif_if bus();
    assign bus.scl = m_scl;
    assign line = m_sda & ~bus.sda_oe;
    assign bus.sda = line;
    assign bus.reg_rdata = rdata;

    i2c_target_regif #(.DEV_ADDR(7'h40), .FILT_LEN(3)) dut (
        .sysclk(clk),
        .reset_n(rst_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    // register file behind the bus plus strobe recorder
    always @(negedge clk) begin
        if (!rst_n) rf = ref_mem;
        if (bus.sda_oe) oe_cnt++;
        if (bus.reg_wr && bus.reg_rd) excl_cnt++;
        if (bus.reg_wr) begin
            wq.push_back({bus.reg_addr, bus.reg_wdata});
            rf[bus.reg_addr] = bus.reg_wdata;
        end
        if (bus.reg_rd) begin
            rq.push_back(bus.reg_addr);
            rdata = rf[bus.reg_addr];
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic start_c;
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic stop_c;
        m_sda = 1'b0;
        tick(Q);
        m_scl = 1'b1;
        tick(Q);
        m_sda = 1'b1;
        tick(2 * Q);
    endtask

    task automatic wbit(input logic b);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        tick(H);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic rbit(output logic b);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(H / 2);
        b = line;
        tick(H / 2);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic wbyte(input logic [7:0] v, output logic ack);
        logic b;
        for (int i = 7; i >= 0; i--) wbit(v[i]);
        rbit(b);
        ack = ~b;
    endtask

    task automatic rbyte(input logic mack, output logic [7:0] v);
        logic b;
        v = '0;
        for (int i = 0; i < 8; i++) begin
            rbit(b);
            v = {v[6:0], b};
        end
        wbit(~mack);
    endtask

    task automatic do_write(input logic [7:0] ofs, input int n);
        int w0;
        logic a;
        w0 = wq.size();
        start_c;
        wbyte(8'h80, a);
        chk("w_dev_ack", a, 1);
        wbyte(ofs, a);
        chk("w_ofs_ack", a, 1);
        for (int i = 0; i < n; i++) begin
            wbyte(dbuf[i], a);
            chk("w_data_ack", a, 1);
        end
        stop_c;
        chk("w_count", wq.size() - w0, n);
        ptr = ofs;
        for (int i = 0; i < n; i++) begin
            chk("w_strobe", (w0 + i < wq.size()) ? 32'(wq[w0 + i]) : 32'hFFFF_FFFF,
                {16'h0, 8'(ptr), dbuf[i]});
            ref_mem[ptr] = dbuf[i];
            ptr = (ptr + 1) % 256;
        end
        chk("w_addr_after", bus.reg_addr, ptr);
    endtask

    task automatic do_read(input logic [7:0] ofs, input int n);
        int r0;
        logic a;
        logic [7:0] v;
        r0 = rq.size();
        start_c;
        wbyte(8'h80, a);
        chk("r_dev_w_ack", a, 1);
        wbyte(ofs, a);
        chk("r_ofs_ack", a, 1);
        start_c;
        wbyte(8'h81, a);
        chk("r_dev_r_ack", a, 1);
        ptr = ofs;
        for (int i = 0; i < n; i++) begin
            rbyte(i != n - 1, v);
            chk("r_data", v, ref_mem[(ptr + i) % 256]);
        end
        chk("r_release", bus.sda_oe, 0);
        stop_c;
        chk("r_count", rq.size() - r0, n);
        for (int i = 0; i < n; i++)
            chk("r_strobe_addr", (r0 + i < rq.size()) ? 32'(rq[r0 + i]) : 32'hFFFF_FFFF, (ptr + i) % 256);
        ptr = (ptr + n) % 256;
        chk("r_addr_after", bus.reg_addr, ptr);
    endtask

    initial begin
        int w0, r0, o0, n, k;
        logic a;
        logic [7:0] ofs;
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'($urandom);
        ref_mem[8'hF0] = 8'h01;
        ref_mem[8'hF1] = 8'h02;
        ref_mem[8'hF2] = 8'hA5;
        tick(4);
        chk("rst_sda_oe", bus.sda_oe, 0);
        chk("rst_wr", bus.reg_wr, 0);
        chk("rst_rd", bus.reg_rd, 0);
        chk("rst_addr", bus.reg_addr, 0);
        chk("rst_wdata", bus.reg_wdata, 0);
        chk("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        tick(8);

        dbuf[0] = 8'h5A;
        dbuf[1] = 8'hC3;
        do_write(8'h20, 2);
        chk("dir_addr_22", bus.reg_addr, 8'h22);

        do_read(8'hF0, 3);

        o0 = oe_cnt;
        w0 = wq.size();
        r0 = rq.size();
        start_c;
        wbyte(8'h82, a);
        chk("nack_dev", a, 0);
        chk("nack_busy_mid", bus.busy, 1);
        wbyte(8'h20, a);
        chk("nack_ignored", a, 0);
        stop_c;
        chk("nack_busy_after", bus.busy, 0);
        chk("nack_no_oe", oe_cnt - o0, 0);
        chk("nack_no_strobe", (wq.size() - w0) + (rq.size() - r0), 0);

        dbuf[0] = 8'h11;
        dbuf[1] = 8'h22;
        do_write(8'hFF, 2);

        w0 = wq.size();
        start_c;
        wbyte(8'h80, a);
        wbyte(8'h30, a);
        for (int i = 0; i < 4; i++) wbit(1'($urandom));
        stop_c;
        chk("part_no_wr", wq.size() - w0, 0);
        chk("part_busy", bus.busy, 0);
        chk("part_sda_oe", bus.sda_oe, 0);
        chk("part_addr", bus.reg_addr, 8'h30);
        dbuf[0] = 8'h77;
        do_write(8'h31, 1);

        for (int it = 0; it < 5; it++) begin
            ofs = 8'($urandom);
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) dbuf[i] = 8'($urandom);
            do_write(ofs, n);
            if ($urandom_range(0, 1) == 0) ofs = 8'($urandom);
            do_read(ofs, $urandom_range(1, 4));
        end

        start_c;
        for (int i = 7; i >= 0; i--) wbit(i == 7);
        m_sda = 1'b1;
        k = 0;
        while (!bus.sda_oe && k < 40) begin
            tick(1);
            k++;
        end
        chk("rst_ack_driven", bus.sda_oe, 1);
        rst_n = 1'b0;
        tick(1);
        chk("mid_rst_sda_oe", bus.sda_oe, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_addr", bus.reg_addr, 0);
        chk("mid_rst_wdata", bus.reg_wdata, 0);
        chk("mid_rst_strobes", {bus.reg_wr, bus.reg_rd}, 0);
        rst_n = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(4 * Q);
        m_sda = 1'b0;
        tick(1);
        m_sda = 1'b1;
        tick(20);
        chk("glitch_busy", bus.busy, 0);

        dbuf[0] = 8'h3C;
        dbuf[1] = 8'h96;
        do_write(8'h80, 2);
        do_read(8'h80, 2);

        chk("wr_rd_excl", excl_cnt, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
